vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out timing generator: pops a show-ahead pixel stream and drives registered RGB/sync/blank.
// Optional colour-bar test pattern (adds port test_pat) is enabled by defining VGA_SCANOUT_TESTPAT_EN.
module vga_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [29:0] FILL_RGB = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [29:0] pix_data,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic        test_pat,
`endif
    input  logic        underflow_clr,
    output logic        pix_rd,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        frame_start,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;

    state_t      state_q, state_d;
    logic [9:0]  hCnt_q, hCnt_d;
    logic [9:0]  vCnt_q, vCnt_d;
    logic [29:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        frameStart_q, frameStart_d;
    logic        underflow_q, underflow_d;

    logic scanning;
    logic active;
    logic srcOk;
    logic lastPos;

    always_comb begin
        scanning = (state_q == RUN) || (state_q == STOP);
        active   = scanning && (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
        lastPos  = (hCnt_q == H_LAST) && (vCnt_q == V_LAST);
`ifdef VGA_SCANOUT_TESTPAT_EN
        srcOk    = pix_valid || test_pat;
        pix_rd   = active && pix_valid && !test_pat;
`else
        srcOk    = pix_valid;
        pix_rd   = active && pix_valid;
`endif
    end

    // STOP keeps scanning so the current frame always completes before IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = PRIME;
            PRIME:   if (srcOk) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (en)           state_d = RUN;
                else if (lastPos) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        hCnt_d = '0;
        vCnt_d = '0;
        if (scanning) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
            end else begin
                hCnt_d = hCnt_q + 10'd1;
                vCnt_d = vCnt_q;
            end
        end
    end

    always_comb begin
        rgb_d = '0;
        if (active) begin
`ifdef VGA_SCANOUT_TESTPAT_EN
            if (test_pat)
                rgb_d = {{10{hCnt_q[8]}}, {10{hCnt_q[7]}}, {10{hCnt_q[6]}}};
            else
`endif
            rgb_d = pix_valid ? pix_data : FILL_RGB;
        end

        hs_d         = !(scanning && (hCnt_q >= HS_START) && (hCnt_q < HS_END));
        vs_d         = !(scanning && (vCnt_q >= VS_START) && (vCnt_q < VS_END));
        blank_d      = active;
        frameStart_d = (state_q == RUN) && (hCnt_q == 10'd0) && (vCnt_q == 10'd0);

        // A new underflow outranks a simultaneous clear.
        underflow_d = underflow_q;
        if (underflow_clr)     underflow_d = 1'b0;
        if (active && !srcOk)  underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_q      <= 1'b0;
            frameStart_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_q      <= blank_d;
            frameStart_q <= frameStart_d;
            underflow_q  <= underflow_d;
        end
    end

    assign VGA_R       = rgb_q[9:0];
    assign VGA_G       = rgb_q[19:10];
    assign VGA_B       = rgb_q[29:20];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign frame_start = frameStart_q;
    assign underflow   = underflow_q;

endmodule
